// File: rtl/pong_ball_if.sv
// pong_ball_if: tick/control/paddle inputs and ball position/event outputs of the Pong ball controller.
interface pong_ball_if;
  logic       refr_tick;
  logic       start;
  logic       pause;
  logic [9:0] pad_l_y;
  logic [9:0] pad_r_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       ball_active;
  logic       hit;
  logic       score_l;
  logic       score_r;
  modport master (
    output refr_tick, start, pause, pad_l_y, pad_r_y,
    input  ball_x, ball_y, ball_active, hit, score_l, score_r
  );
  modport slave (
    input  refr_tick, start, pause, pad_l_y, pad_r_y,
    output ball_x, ball_y, ball_active, hit, score_l, score_r
  );
endinterface

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: per-frame Pong ball motion with wall/paddle bounces and miss scoring.
// Optional PONG_BALL_SPEEDUP_EN: velocity +1 every 4th paddle hit, capped at VEL_MAX, reset on score.
module pong_ball_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 8,
  parameter int VEL         = 2,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int L_PADDLE_X  = 24,
  parameter int R_PADDLE_X  = 608,
  parameter int SERVE_TICKS = 60,
  parameter int VEL_MAX     = 6
) (
  input logic        clk,
  input logic        rst,
  pong_ball_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY} state_t;
  localparam int CW = $clog2(SERVE_TICKS + 1);
  localparam int VW = $clog2(VEL_MAX + 1);
  localparam logic [9:0] CX = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0] CY = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] PH = 11'(PADDLE_H);
  localparam logic [10:0] RX = 11'(R_PADDLE_X);
  localparam logic [10:0] LF = 11'(L_PADDLE_X + PADDLE_W);
  localparam logic [10:0] XM = 11'(H_RES);
  localparam logic [10:0] YM = 11'(V_RES - BALL_SIZE);
  state_t state, state_n;
  logic [9:0] bx, by, bx_n, by_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [VW-1:0] vel;
  logic [10:0] x, y, v, pl, pr;
  logic dx, dy, dx_n, dy_n, act_q, act_n, hit_q, hit_n, sl_q, sl_n, sr_q, sr_n;
  logic tick, play, miss, ov_l, ov_r, hit_l, hit_r, miss_l, miss_r, bot, top;
  assign tick = bus.refr_tick & ~bus.pause;
  assign play = tick && state == PLAY;
  assign x = {1'b0, bx};
  assign y = {1'b0, by};
  assign v = 11'(vel);
  assign pl = {1'b0, bus.pad_l_y};
  assign pr = {1'b0, bus.pad_r_y};
  assign ov_l = y + BS > pl && y < pl + PH;
  assign ov_r = y + BS > pr && y < pr + PH;
  // A paddle only catches the ball while it is still in front of the face.
  assign hit_r = dx && x + BS <= RX && x + BS + v >= RX && ov_r;
  assign hit_l = !dx && x >= LF && x <= LF + v && ov_l;
  assign miss_r = dx && !hit_r && x + BS + v >= XM;
  assign miss_l = !dx && !hit_l && x <= v;
  assign miss = miss_l | miss_r;
  assign bot = dy && y + v >= YM;
  assign top = !dy && y <= v;
`ifdef PONG_BALL_SPEEDUP_EN
  logic [VW-1:0] vel_n;
  logic [1:0] hits, hits_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vel <= VW'(VEL);
      hits <= 2'd0;
    end else begin
      vel <= vel_n;
      hits <= hits_n;
    end
  always_comb begin
    hits_n = (play && miss) ? 2'd0 : hit_n ? hits + 2'd1 : hits;
    vel_n = (play && miss) ? VW'(VEL) : (hit_n && hits == 2'd3 && vel < VW'(VEL_MAX)) ? vel + 1'b1 : vel;
  end
`else
  assign vel = VW'(VEL);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bx <= CX;
      by <= CY;
      dx <= 1'b1;
      dy <= 1'b1;
      cnt <= '0;
      act_q <= 1'b0;
      hit_q <= 1'b0;
      sl_q <= 1'b0;
      sr_q <= 1'b0;
    end else begin
      state <= state_n;
      bx <= bx_n;
      by <= by_n;
      dx <= dx_n;
      dy <= dy_n;
      cnt <= cnt_n;
      act_q <= act_n;
      hit_q <= hit_n;
      sl_q <= sl_n;
      sr_q <= sr_n;
    end
  always_comb
    state_n = (state == IDLE && bus.start) ? SERVE :
              (tick && state == SERVE && cnt == CW'(1)) ? PLAY :
              (play && miss) ? SERVE : state;
  // On a miss the ball recentres and heads toward the player who missed; dy is kept.
  always_comb begin
    bx_n = !play ? bx : miss ? CX : hit_r ? 10'(RX - BS) : hit_l ? 10'(LF) : dx ? 10'(x + v) : 10'(x - v);
    by_n = !play ? by : miss ? CY : bot ? 10'(YM) : top ? 10'd0 : dy ? 10'(y + v) : 10'(y - v);
    dx_n = !play ? dx : miss ? miss_r : hit_r ? 1'b0 : hit_l ? 1'b1 : dx;
    dy_n = (play && !miss) ? (bot ? 1'b0 : top ? 1'b1 : dy) : dy;
    cnt_n = ((state == IDLE && bus.start) || (play && miss)) ? CW'(SERVE_TICKS) :
            (tick && state == SERVE) ? cnt - 1'b1 : cnt;
    hit_n = play && (hit_l || hit_r);
    sl_n = play && miss_r;
    sr_n = play && miss_l;
    act_n = state_n != IDLE;
  end
  assign bus.ball_x = bx;
  assign bus.ball_y = by;
  assign bus.ball_active = act_q;
  assign bus.hit = hit_q;
  assign bus.score_l = sl_q;
  assign bus.score_r = sr_q;
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: scoreboard bench; a behavioural ball model predicts every clock of outputs.
module tb_pong_ball_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pong_ball_if bus();
  pong_ball_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int x; int y; int a; int h; int sl; int sr;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_err = 0;
  int mx, my, mdx, mdy, mst, mcnt, mv, n_hits, n_scores;
  int eh, esl, esr;
  int dut_hits = 0, dut_sl = 0, dut_sr = 0;
  bit avoid_l = 0, avoid_r = 0;
`ifdef PONG_BALL_SPEEDUP_EN
  int mh;
`endif
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Tracking keeps the ball inside the paddle span; avoiding parks it well clear.
  function automatic int pad_for(bit avoid);
    if (!avoid) return (my >= 20) ? my - 20 : 0;
    return (my < 240) ? 400 : 0;
  endfunction
  task automatic model_reset;
    mx = 316; my = 236; mdx = 1; mdy = 1; mst = 0; mcnt = 0; mv = 2;
`ifdef PONG_BALL_SPEEDUP_EN
    mh = 0;
`endif
  endtask
  task automatic model_step(bit t, bit s);
    int pl, pr, nx, ndx, ovl, ovr;
    eh = 0; esl = 0; esr = 0;
    pl = bus.pad_l_y; pr = bus.pad_r_y;
    if (mst == 0) begin
      if (s) begin mst = 1; mcnt = 60; end
    end else if (t && !bus.pause) begin
      if (mst == 1) begin
        mcnt--;
        if (mcnt == 0) mst = 2;
      end else begin
        ovl = (my + 8 > pl) && (my < pl + 64);
        ovr = (my + 8 > pr) && (my < pr + 64);
        nx = mx; ndx = mdx;
        if (mdx == 1) begin
          if (mx + 8 <= 608 && mx + 8 + mv >= 608 && ovr) begin nx = 600; ndx = 0; eh = 1; end
          else if (mx + 8 + mv >= 640) esl = 1;
          else nx = mx + mv;
        end else begin
          if (mx >= 32 && mx - mv <= 32 && ovl) begin nx = 32; ndx = 1; eh = 1; end
          else if (mx <= mv) esr = 1;
          else nx = mx - mv;
        end
        if (esl || esr) begin
          mx = 316; my = 236; mdx = esl; mst = 1; mcnt = 60; mv = 2; n_scores++;
`ifdef PONG_BALL_SPEEDUP_EN
          mh = 0;
`endif
        end else begin
          mx = nx; mdx = ndx;
          if (mdy == 1) begin
            if (my + mv >= 472) begin my = 472; mdy = 0; end else my += mv;
          end else begin
            if (my <= mv) begin my = 0; mdy = 1; end else my -= mv;
          end
          if (eh == 1) begin
            n_hits++;
`ifdef PONG_BALL_SPEEDUP_EN
            mh = (mh + 1) % 4;
            if (mh == 0 && mv < 6) mv++;
`endif
          end
        end
      end
    end
    sb.push_back('{mx, my, (mst != 0), eh, esl, esr});
  endtask
  task automatic step(bit t, bit s);
    exp_t e;
    bus.pad_l_y = 10'(pad_for(avoid_l));
    bus.pad_r_y = 10'(pad_for(avoid_r));
    bus.refr_tick = t;
    bus.start = s;
    model_step(t, s);
    @(negedge clk);
    e = sb.pop_front();
    chk("ball_x", int'(bus.ball_x), e.x);
    chk("ball_y", int'(bus.ball_y), e.y);
    chk("ball_active", int'(bus.ball_active), e.a);
    chk("hit", int'(bus.hit), e.h);
    chk("score_l", int'(bus.score_l), e.sl);
    chk("score_r", int'(bus.score_r), e.sr);
    dut_hits += int'(bus.hit);
    dut_sl += int'(bus.score_l);
    dut_sr += int'(bus.score_r);
    bus.refr_tick = 1'b0;
    bus.start = 1'b0;
  endtask
  task automatic tick;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask
  initial begin
    int x0, d;
    bus.refr_tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.pad_l_y = '0; bus.pad_r_y = '0;
    model_reset;
    n_hits = 0; n_scores = 0;
    repeat (2) @(negedge clk);
    chk("rst_x", int'(bus.ball_x), 316);
    chk("rst_y", int'(bus.ball_y), 236);
    chk("rst_active", int'(bus.ball_active), 0);
    chk("rst_hit", int'(bus.hit), 0);
    chk("rst_score", int'(bus.score_l | bus.score_r), 0);
    rst = 1'b0;
    repeat (3) tick;
    step(1'b0, 1'b1);
    repeat (60) tick;
    chk("serve_hold_x", int'(bus.ball_x), 316);
    tick;
    chk("play1_x", int'(bus.ball_x), 318);
    chk("play1_y", int'(bus.ball_y), 238);
    for (int i = 0; i < 3000 && n_hits < 4; i++) tick;
    chk("rally_hits", dut_hits, 4);
    x0 = bus.ball_x;
    tick;
    d = int'(bus.ball_x) - x0;
`ifdef PONG_BALL_SPEEDUP_EN
    chk("step_after_4_hits", d, 3);
`else
    chk("step_after_4_hits", d, 2);
`endif
    avoid_r = 1;
    for (int i = 0; i < 3000 && n_scores < 1; i++) tick;
    chk("score_l_pulses", dut_sl, 1);
    chk("recentre_x", int'(bus.ball_x), 316);
    chk("recentre_y", int'(bus.ball_y), 236);
    repeat (60) tick;
    tick;
    chk("serve_right_step", int'(bus.ball_x), 318);
    avoid_r = 0;
    avoid_l = 1;
    for (int i = 0; i < 3000 && n_scores < 2; i++) tick;
    chk("score_r_pulses", dut_sr, 1);
    repeat (60) tick;
    tick;
    chk("serve_left_step", int'(bus.ball_x), 314);
    bus.pause = 1'b1;
    repeat (10) tick;
    chk("pause_hold_x", int'(bus.ball_x), 314);
    bus.pause = 1'b0;
    tick;
    chk("resume_x", int'(bus.ball_x), 312);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_x", int'(bus.ball_x), 316);
    chk("async_rst_y", int'(bus.ball_y), 236);
    chk("async_rst_active", int'(bus.ball_active), 0);
    model_reset;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick;
    chk("idle_after_rst", int'(bus.ball_active), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
